// File: rtl/vector_writeback_unit_pkg.sv
// Shared constants and register-file / FSM encodings for the vector write-back unit.
// The optional mask merge is selected with the VWB_MASK_EN macro.
`ifndef VWB_DEFINES_DONE
`define VWB_DEFINES_DONE
`define RF_NOP          2'b00
`define VECTOR_RF_WRITE 2'b01
`define RF_FINISHED     2'b10
`define VWB_IDLE        2'b00
`define VWB_COLLECT     2'b01
`define VWB_WRITE       2'b10
`define VWB_WAIT        2'b11
`endif

package vector_writeback_unit_pkg;
    localparam int VWB_LEN              = 32;
    localparam int VWB_VECTOR_SIZE      = 8;
    localparam int VWB_ENTRY_INDEX_SIZE = 3;
    localparam int VWB_LANES            = 2;

    typedef logic [1:0] vwb_state_t;
endpackage

// File: rtl/vector_writeback_unit_lane_merge.sv
// Combinational per-element merge of collected results with the old destination.
// VWB_MASK_EN selects whether the v0 mask participates in the merge.
module vwb_lane_merge
    import vector_writeback_unit_pkg::*;
#(
    parameter int LEN              = VWB_LEN,
    parameter int VECTOR_SIZE      = VWB_VECTOR_SIZE,
    parameter int ENTRY_INDEX_SIZE = VWB_ENTRY_INDEX_SIZE
) (
    input  logic [VECTOR_SIZE*LEN-1:0]  buffer,
    input  logic [VECTOR_SIZE*LEN-1:0]  old_data,
    input  logic [VECTOR_SIZE-1:0]      mask,
    input  logic [ENTRY_INDEX_SIZE:0]   length,
    output logic [VECTOR_SIZE*LEN-1:0]  rf_data
);

    for (genvar i = 0; i < VECTOR_SIZE; i++) begin : g_elem
        localparam logic [ENTRY_INDEX_SIZE:0] ELEM = (ENTRY_INDEX_SIZE+1)'(i);
        logic take_new;
`ifdef VWB_MASK_EN
        assign take_new = (ELEM < length) && mask[i];
`else
        // Mask stays referenced so the port is kept, but it never deselects an element.
        assign take_new = (ELEM < length) && (mask[i] | 1'b1);
`endif
        assign rf_data[i*LEN +: LEN] = take_new ? buffer[i*LEN +: LEN] : old_data[i*LEN +: LEN];
    end

endmodule

// File: rtl/vector_writeback_unit.sv
// Vector register-file write-back initiator: collects lane beats, merges, writes, waits.
// Mask-aware merging is enabled with the VWB_MASK_EN macro (see vwb_lane_merge).
module vector_writeback_unit
    import vector_writeback_unit_pkg::*;
#(
    parameter int LEN              = VWB_LEN,
    parameter int VECTOR_SIZE      = VWB_VECTOR_SIZE,
    parameter int ENTRY_INDEX_SIZE = VWB_ENTRY_INDEX_SIZE,
    parameter int LANES            = VWB_LANES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy_in,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic [4:0]                    start_rd,
    input  logic [ENTRY_INDEX_SIZE:0]     start_length,
    input  logic [VECTOR_SIZE-1:0]        start_mask,
    input  logic [VECTOR_SIZE*LEN-1:0]    start_old_data,
    input  logic                          elem_valid,
    output logic                          elem_ready,
    input  logic [LANES*LEN-1:0]          elem_data,
    output logic [1:0]                    rf_signal,
    output logic [4:0]                    rf_rd,
    output logic [VECTOR_SIZE*LEN-1:0]    rf_data,
    output logic [ENTRY_INDEX_SIZE:0]     rf_length,
    output logic                          write_back_enabled,
    input  logic [1:0]                    rf_status,
    output logic                          done
);

    localparam logic [1:0] S_IDLE    = `VWB_IDLE;
    localparam logic [1:0] S_COLLECT = `VWB_COLLECT;
    localparam logic [1:0] S_WRITE   = `VWB_WRITE;
    localparam logic [1:0] S_WAIT    = `VWB_WAIT;

    localparam logic [ENTRY_INDEX_SIZE:0]   MAX_LEN = (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE);
    localparam logic [ENTRY_INDEX_SIZE+1:0] STEP    = (ENTRY_INDEX_SIZE+2)'(LANES);

    vwb_state_t                   state;
    logic [ENTRY_INDEX_SIZE:0]    idx;
    logic [ENTRY_INDEX_SIZE:0]    len_q;
    logic [4:0]                   rd_q;
    logic [VECTOR_SIZE-1:0]       mask_q;
    logic [VECTOR_SIZE*LEN-1:0]   old_q;
    logic [VECTOR_SIZE*LEN-1:0]   buf_q;
    logic                         done_q;

    logic [ENTRY_INDEX_SIZE:0]    len_clamped;
    logic [ENTRY_INDEX_SIZE+1:0]  idx_step;

    assign len_clamped = (start_length > MAX_LEN) ? MAX_LEN : start_length;
    assign idx_step    = {1'b0, idx} + STEP;

    // Buffer starts as a copy of the old contents; lanes overwrite only in-body elements.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            len_q  <= '0;
            rd_q   <= '0;
            mask_q <= '0;
            old_q  <= '0;
            buf_q  <= '0;
            done_q <= 1'b0;
        end else if (rdy_in) begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        rd_q   <= start_rd;
                        mask_q <= start_mask;
                        old_q  <= start_old_data;
                        buf_q  <= start_old_data;
                        len_q  <= len_clamped;
                        idx    <= '0;
                        state  <= (len_clamped == '0) ? S_WRITE : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (elem_valid) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (int'(idx) + k < int'(len_q))
                                buf_q[(int'(idx) + k)*LEN +: LEN] <= elem_data[k*LEN +: LEN];
                        end
                        idx <= idx_step[ENTRY_INDEX_SIZE:0];
                        if (idx_step >= {1'b0, len_q})
                            state <= S_WRITE;
                    end
                end
                // A stale FINISHED is never looked at here, only in WAIT.
                S_WRITE: state <= S_WAIT;
                S_WAIT: begin
                    if (rf_status == `RF_FINISHED) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    vwb_lane_merge #(
        .LEN              (LEN),
        .VECTOR_SIZE      (VECTOR_SIZE),
        .ENTRY_INDEX_SIZE (ENTRY_INDEX_SIZE)
    ) u_merge (
        .buffer   (buf_q),
        .old_data (old_q),
        .mask     (mask_q),
        .length   (len_q),
        .rf_data  (rf_data)
    );

    assign start_ready        = rdy_in && (state == S_IDLE);
    assign elem_ready         = rdy_in && (state == S_COLLECT);
    assign write_back_enabled = (state == S_WRITE) || (state == S_WAIT);
    assign rf_signal          = write_back_enabled ? `VECTOR_RF_WRITE : `RF_NOP;
    assign rf_rd              = rd_q;
    assign rf_length          = len_q;
    assign done               = done_q;

endmodule
